// File: rtl/fifo_arbiter_pkg.sv
// Shared definitions for the FIFO arbiter: FSM encoding, requester indices
// and default parameter values.
package fifo_arbiter_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StIssue = 2'd1,
    StWait  = 2'd2
  } state_e;

  // Requester indices in round-robin order.
  localparam logic [1:0] IdxP0 = 2'd0;
  localparam logic [1:0] IdxP1 = 2'd1;
  localparam logic [1:0] IdxC0 = 2'd2;
  localparam logic [1:0] IdxC1 = 2'd3;

  localparam int unsigned DataWDefault = 32;
  localparam int unsigned TmoDefault   = 4;

  // Index of the set bit of a one-hot (or zero) 4-bit vector.
  function automatic logic [1:0] onehot_to_idx(input logic [3:0] oh);
    logic [1:0] idx;
    idx = '0;
    for (int i = 0; i < 4; i++) begin
      if (oh[i]) idx = 2'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/rr_pick4.sv
// Four-way round-robin picker: the first set request at or after the pointer
// (wrapping) wins. Purely combinational.
module rr_pick4 (
  input  logic [3:0] req,
  input  logic [1:0] ptr,
  output logic [3:0] gnt
);

  logic [1:0] idx;

  // Scan offsets from farthest to nearest so the nearest set request wins.
  always_comb begin
    gnt = '0;
    idx = '0;
    for (int k = 3; k >= 0; k--) begin
      idx = ptr + 2'(k);
      if (req[idx]) gnt = 4'b0001 << idx;
    end
  end

endmodule

// File: rtl/fifo_arbiter.sv
// Arbitrates two producers and two consumers onto a single FIFO port. One
// operation is in flight at a time: grant in IDLE, command in ISSUE, wait for
// the FIFO response (or a timeout) in WAIT.
module fifo_arbiter
  import fifo_arbiter_pkg::*;
#(
  parameter int unsigned DATA_W = DataWDefault,
  parameter int unsigned TMO    = TmoDefault
) (
  input  logic              clk,
  input  logic              reset_n,
  // producers
  input  logic [1:0]        p_req,
  input  logic [DATA_W-1:0] p_din0,
  input  logic [DATA_W-1:0] p_din1,
  output logic [1:0]        p_ack,
  output logic [1:0]        p_err,
  // consumers
  input  logic [1:0]        c_req,
  output logic [1:0]        c_ack,
  output logic [1:0]        c_err,
  output logic [DATA_W-1:0] c_dout,
  // FIFO side
  output logic              wr_en,
  output logic              rd_en,
  output logic [DATA_W-1:0] din,
  input  logic [DATA_W-1:0] dout,
  input  logic [3:0]        data_count,
  input  logic              wr_ack,
  input  logic              wr_err,
  input  logic              rd_ack,
  input  logic              rd_err
);

  localparam int unsigned CntW = $clog2(TMO + 1);

  state_e            state_q, state_d;
  logic [1:0]        win_q, win_d;
  logic [1:0]        ptr_q, ptr_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [1:0]        p_ack_q, p_ack_d;
  logic [1:0]        p_err_q, p_err_d;
  logic [1:0]        c_ack_q, c_ack_d;
  logic [1:0]        c_err_q, c_err_d;
  logic [DATA_W-1:0] c_dout_q, c_dout_d;

  logic       fifo_full;
  logic       fifo_empty;
  logic [3:0] elig;
  logic [3:0] gnt;
  logic [1:0] gnt_idx;
  logic       win_is_wr;
  logic       resp_ack;
  logic       resp_err;
  logic [CntW-1:0] cnt_inc;
  logic       tmo_hit;

  assign fifo_full  = (data_count >= 4'd8);
  assign fifo_empty = (data_count == 4'd0);

  // A requester whose completion pulse is showing this cycle still has its
  // request up (it drops it on seeing the pulse), so keep it out of arbitration.
  assign elig[1:0] = p_req & {2{~fifo_full}}  & ~(p_ack_q | p_err_q);
  assign elig[3:2] = c_req & {2{~fifo_empty}} & ~(c_ack_q | c_err_q);

  rr_pick4 u_pick (
    .req (elig),
    .ptr (ptr_q),
    .gnt (gnt)
  );

  assign gnt_idx   = onehot_to_idx(gnt);
  assign win_is_wr = (win_q == IdxP0) || (win_q == IdxP1);
  assign resp_ack  = win_is_wr ? wr_ack : rd_ack;
  assign resp_err  = win_is_wr ? wr_err : rd_err;
  assign cnt_inc   = cnt_q + CntW'(1);
  assign tmo_hit   = (cnt_inc == CntW'(TMO));

  // Next-state, grant and completion-pulse decode.
  always_comb begin
    state_d  = state_q;
    win_d    = win_q;
    ptr_d    = ptr_q;
    cnt_d    = cnt_q;
    p_ack_d  = '0;
    p_err_d  = '0;
    c_ack_d  = '0;
    c_err_d  = '0;
    c_dout_d = '0;
    unique case (state_q)
      StIdle: begin
        if (|elig) begin
          win_d   = gnt_idx;
          ptr_d   = gnt_idx + 2'd1;
          state_d = StIssue;
        end
      end
      StIssue: begin
        cnt_d   = '0;
        state_d = StWait;
      end
      StWait: begin
        // err beats ack when both arrive together
        if (resp_err || (!resp_ack && tmo_hit)) begin
          if (win_is_wr) p_err_d[win_q[0]] = 1'b1;
          else           c_err_d[win_q[0]] = 1'b1;
          state_d = StIdle;
        end else if (resp_ack) begin
          if (win_is_wr) begin
            p_ack_d[win_q[0]] = 1'b1;
          end else begin
            c_ack_d[win_q[0]] = 1'b1;
            c_dout_d          = dout;
          end
          state_d = StIdle;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and registered outputs; reset abandons any in-flight operation.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= StIdle;
      win_q    <= IdxP0;
      ptr_q    <= IdxP0;
      cnt_q    <= '0;
      p_ack_q  <= '0;
      p_err_q  <= '0;
      c_ack_q  <= '0;
      c_err_q  <= '0;
      c_dout_q <= '0;
    end else begin
      state_q  <= state_d;
      win_q    <= win_d;
      ptr_q    <= ptr_d;
      cnt_q    <= cnt_d;
      p_ack_q  <= p_ack_d;
      p_err_q  <= p_err_d;
      c_ack_q  <= c_ack_d;
      c_err_q  <= c_err_d;
      c_dout_q <= c_dout_d;
    end
  end

  assign p_ack  = p_ack_q;
  assign p_err  = p_err_q;
  assign c_ack  = c_ack_q;
  assign c_err  = c_err_q;
  assign c_dout = c_dout_q;

  // FIFO commands decode straight from the ISSUE state.
  assign wr_en = (state_q == StIssue) && win_is_wr;
  assign rd_en = (state_q == StIssue) && !win_is_wr;
  assign din   = wr_en ? ((win_q == IdxP1) ? p_din1 : p_din0) : '0;

endmodule

// File: tb/tb_fifo_arbiter.sv
// Directed bench for fifo_arbiter with a small responding FIFO model.
module tb_fifo_arbiter;

  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic [1:0]    p_req = '0;
  logic [1:0]    c_req = '0;
  logic [DW-1:0] p_din0 = '0;
  logic [DW-1:0] p_din1 = '0;
  logic [1:0]    p_ack, p_err, c_ack, c_err;
  logic [DW-1:0] c_dout, din;
  logic          wr_en, rd_en;
  logic [DW-1:0] dout = '0;
  logic [3:0]    data_count;
  logic          wr_ack = 1'b0;
  logic          wr_err = 1'b0;
  logic          rd_ack = 1'b0;
  logic          rd_err = 1'b0;

  // FIFO model controls (written by the stimulus process only)
  bit            track = 1'b0;
  logic [3:0]    fixed_cnt = '0;
  int            resp_mode = 0; // 0 ack, 1 silent, 2 err, 3 ack+err
  logic [DW-1:0] rd_fill = '0;

  // FIFO model state (written by the model process only)
  int            model_cnt = 0;
  logic          pend_wr = 1'b0;
  logic          pend_rd = 1'b0;
  logic [DW-1:0] din_cap = '0;
  logic [DW-1:0] mq[$];

  int n_cmp = 0;
  int n_bad = 0;
  int ev[$];
  int wr_cnt, rd_cnt, both_cnt;

  fifo_arbiter #(.DATA_W(DW), .TMO(4)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .p_req      (p_req),
    .p_din0     (p_din0),
    .p_din1     (p_din1),
    .p_ack      (p_ack),
    .p_err      (p_err),
    .c_req      (c_req),
    .c_ack      (c_ack),
    .c_err      (c_err),
    .c_dout     (c_dout),
    .wr_en      (wr_en),
    .rd_en      (rd_en),
    .din        (din),
    .dout       (dout),
    .data_count (data_count),
    .wr_ack     (wr_ack),
    .wr_err     (wr_err),
    .rd_ack     (rd_ack),
    .rd_err     (rd_err)
  );

  always #5 clk = ~clk;

  assign data_count = track ? 4'(model_cnt) : fixed_cnt;

  // FIFO model: responds in the cycle after a command (the arbiter's WAIT).
  always @(negedge clk) begin
    wr_ack = 1'b0; wr_err = 1'b0; rd_ack = 1'b0; rd_err = 1'b0;
    if (!reset_n) begin pend_wr = 1'b0; pend_rd = 1'b0; end
    if (!track) begin model_cnt = int'(fixed_cnt); mq.delete(); end
    if (pend_wr) begin
      case (resp_mode)
        0: begin wr_ack = 1'b1; mq.push_back(din_cap); model_cnt++; end
        2: wr_err = 1'b1;
        3: begin wr_ack = 1'b1; wr_err = 1'b1; end
        default: ;
      endcase
    end
    if (pend_rd) begin
      case (resp_mode)
        0: begin
          rd_ack = 1'b1;
          dout = (mq.size() > 0) ? mq.pop_front() : rd_fill;
          model_cnt--;
        end
        2: rd_err = 1'b1;
        3: begin rd_ack = 1'b1; rd_err = 1'b1; dout = rd_fill; end
        default: ;
      endcase
    end
    pend_wr = wr_en && reset_n;
    pend_rd = rd_en && reset_n;
    din_cap = din;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  task automatic do_reset();
    reset_n = 1'b0; p_req = '0; c_req = '0; p_din0 = '0; p_din1 = '0;
    track = 1'b0; fixed_cnt = '0; resp_mode = 0; rd_fill = '0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic clear_watch();
    ev.delete(); wr_cnt = 0; rd_cnt = 0; both_cnt = 0;
  endtask

  // Log completions and commands for n cycles; optionally drop finished requests.
  task automatic watch(input int n, input bit auto_drop);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      if (wr_en) wr_cnt++;
      if (rd_en) rd_cnt++;
      if (wr_en && rd_en) both_cnt++;
      for (int i = 0; i < 2; i++) begin
        if (p_ack[i]) ev.push_back(i);
        if (c_ack[i]) ev.push_back(2 + i);
        if (p_err[i]) ev.push_back(4 + i);
        if (c_err[i]) ev.push_back(6 + i);
      end
      if (auto_drop) begin
        p_req = p_req & ~(p_ack | p_err);
        c_req = c_req & ~(c_ack | c_err);
      end
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({p_ack, p_err, c_ack, c_err, wr_en, rd_en} !== 10'd0) begin
      n_bad++;
      $display("FAIL reset_flags: got %b want 0", {p_ack, p_err, c_ack, c_err, wr_en, rd_en});
    end
    n_cmp++;
    if (c_dout !== '0) begin n_bad++; $display("FAIL reset_cdout: got %h want 0", c_dout); end
    n_cmp++;
    if (din !== '0) begin n_bad++; $display("FAIL reset_din: got %h want 0", din); end
  endtask

  task automatic test_single_write();
    do_reset();
    track = 1'b1;
    p_din0 = 32'hA5;
    p_req = 2'b01;
    @(negedge clk);
    n_cmp++;
    if ({wr_en, rd_en} !== 2'b10) begin
      n_bad++; $display("FAIL sw_wren: got %b want 10", {wr_en, rd_en});
    end
    n_cmp++;
    if (din !== 32'hA5) begin n_bad++; $display("FAIL sw_din: got %h want a5", din); end
    @(negedge clk);
    n_cmp++;
    if ({p_ack, wr_en} !== 3'b000) begin
      n_bad++; $display("FAIL sw_early: got %b want 000", {p_ack, wr_en});
    end
    @(negedge clk);
    n_cmp++;
    if ({p_ack, p_err} !== 4'b0100) begin
      n_bad++; $display("FAIL sw_ack: got %b want 0100", {p_ack, p_err});
    end
    p_req = 2'b00;
    @(negedge clk);
    n_cmp++;
    if ({p_ack, wr_en} !== 3'b000) begin
      n_bad++; $display("FAIL sw_pulse: got %b want 000", {p_ack, wr_en});
    end
  endtask

  task automatic test_alternate_until_full();
    do_reset();
    track = 1'b1;
    p_din0 = 32'h11;
    p_din1 = 32'h22;
    p_req = 2'b11;
    clear_watch();
    watch(50, 1'b0);
    n_cmp++;
    if (ev.size() != 8) begin n_bad++; $display("FAIL alt_count: got %0d want 8", ev.size()); end
    for (int i = 0; i < ev.size() && i < 8; i++) begin
      n_cmp++;
      if (ev[i] != i % 2) begin
        n_bad++; $display("FAIL alt_order[%0d]: got %0d want %0d", i, ev[i], i % 2);
      end
    end
    n_cmp++;
    if (wr_cnt != 8) begin n_bad++; $display("FAIL alt_wren: got %0d want 8", wr_cnt); end
    n_cmp++;
    if (both_cnt != 0 || rd_cnt != 0) begin
      n_bad++; $display("FAIL alt_rden: got %0d/%0d want 0/0", rd_cnt, both_cnt);
    end
    p_req = 2'b00;
  endtask

  task automatic test_read_wait_empty();
    do_reset();
    rd_fill = 32'hDEADBEEF;
    c_req = 2'b10;
    clear_watch();
    watch(6, 1'b1);
    n_cmp++;
    if (rd_cnt != 0 || ev.size() != 0) begin
      n_bad++; $display("FAIL rd_empty: got %0d/%0d want 0/0", rd_cnt, ev.size());
    end
    fixed_cnt = 4'd1;
    @(negedge clk);
    n_cmp++;
    if ({wr_en, rd_en} !== 2'b01) begin
      n_bad++; $display("FAIL rd_issue: got %b want 01", {wr_en, rd_en});
    end
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({c_ack, c_err} !== 4'b1000) begin
      n_bad++; $display("FAIL rd_ack: got %b want 1000", {c_ack, c_err});
    end
    n_cmp++;
    if (c_dout !== 32'hDEADBEEF) begin
      n_bad++; $display("FAIL rd_data: got %h want deadbeef", c_dout);
    end
    c_req = 2'b00;
  endtask

  task automatic test_rr_wrap();
    int exp_ord[5];
    exp_ord = '{0, 1, 2, 3, 0};
    do_reset();
    fixed_cnt = 4'd4;
    rd_fill = 32'h1234;
    p_req = 2'b11;
    c_req = 2'b11;
    clear_watch();
    watch(20, 1'b0);
    n_cmp++;
    if (ev.size() < 5) begin n_bad++; $display("FAIL rr_count: got %0d want >=5", ev.size()); end
    for (int i = 0; i < 5 && i < ev.size(); i++) begin
      n_cmp++;
      if (ev[i] != exp_ord[i]) begin
        n_bad++; $display("FAIL rr_order[%0d]: got %0d want %0d", i, ev[i], exp_ord[i]);
      end
    end
    p_req = 2'b00;
    c_req = 2'b00;
  endtask

  task automatic test_timeout();
    int err_at;
    int err_n;
    bit rd_first;
    do_reset();
    fixed_cnt = 4'd1;
    resp_mode = 1;
    c_req = 2'b01;
    err_at = -1; err_n = 0; rd_first = 1'b0;
    clear_watch();
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      if (k == 1) rd_first = rd_en;
      if (rd_en) rd_cnt++;
      if (c_ack != 2'b00) ev.push_back(k);
      if (c_err == 2'b01) begin
        err_n++;
        if (err_at < 0) err_at = k;
        c_req = 2'b00;
      end
    end
    n_cmp++;
    if (rd_first !== 1'b1) begin n_bad++; $display("FAIL tmo_issue: got %b want 1", rd_first); end
    n_cmp++;
    if (err_at != 6) begin n_bad++; $display("FAIL tmo_cycle: got %0d want 6", err_at); end
    n_cmp++;
    if (err_n != 1 || ev.size() != 0 || rd_cnt != 1) begin
      n_bad++;
      $display("FAIL tmo_pulse: got err=%0d ack=%0d rd=%0d want 1/0/1", err_n, ev.size(), rd_cnt);
    end
    resp_mode = 0;
    c_req = 2'b10;
    @(negedge clk);
    n_cmp++;
    if (rd_en !== 1'b1) begin n_bad++; $display("FAIL tmo_idle: got %b want 1", rd_en); end
    repeat (2) @(negedge clk);
    c_req = 2'b00;
  endtask

  task automatic test_err_paths();
    do_reset();
    fixed_cnt = 4'd4;
    resp_mode = 3;
    p_req = 2'b10;
    clear_watch();
    watch(5, 1'b1);
    n_cmp++;
    if (ev.size() != 1 || ev[0] != 5) begin
      n_bad++; $display("FAIL err_wins: got n=%0d ev0=%0d want 1/5", ev.size(),
                        (ev.size() > 0) ? ev[0] : -1);
    end
    resp_mode = 2;
    c_req = 2'b01;
    clear_watch();
    watch(5, 1'b1);
    n_cmp++;
    if (ev.size() != 1 || ev[0] != 6) begin
      n_bad++; $display("FAIL rd_err: got n=%0d ev0=%0d want 1/6", ev.size(),
                        (ev.size() > 0) ? ev[0] : -1);
    end
  endtask

  task automatic test_full_blocks();
    do_reset();
    fixed_cnt = 4'd8;
    p_req = 2'b01;
    clear_watch();
    watch(6, 1'b0);
    n_cmp++;
    if (wr_cnt != 0 || ev.size() != 0) begin
      n_bad++; $display("FAIL full_block: got wr=%0d ev=%0d want 0/0", wr_cnt, ev.size());
    end
    p_req = 2'b00;
  endtask

  task automatic test_reset_mid();
    do_reset();
    resp_mode = 1;
    p_din0 = 32'h0A;
    p_din1 = 32'h0B;
    p_req = 2'b01;
    @(negedge clk);
    #1 reset_n = 1'b0;
    #1;
    n_cmp++;
    if ({wr_en, din} !== {1'b0, 32'h0}) begin
      n_bad++; $display("FAIL rst_issue: got %b/%h want 0/0", wr_en, din);
    end
    @(negedge clk);
    #1 reset_n = 1'b1;
    resp_mode = 0;
    @(negedge clk);   // grant P0, pointer moves to P1
    @(negedge clk);   // WAIT; model raises wr_ack this cycle
    #1 reset_n = 1'b0;
    #1;
    n_cmp++;
    if ({p_ack, p_err, c_ack, c_err, wr_en, rd_en, c_dout} !== '0) begin
      n_bad++; $display("FAIL rst_wait: got %b want 0", {p_ack, p_err, c_ack, c_err, wr_en, rd_en});
    end
    p_req = 2'b00;
    @(negedge clk);
    #1 reset_n = 1'b1;
    clear_watch();
    watch(3, 1'b0);
    n_cmp++;
    if (ev.size() != 0) begin n_bad++; $display("FAIL rst_nopulse: got %0d want 0", ev.size()); end
    p_req = 2'b11;
    @(negedge clk);
    n_cmp++;
    if ({wr_en, din} !== {1'b1, 32'h0A}) begin
      n_bad++; $display("FAIL rst_ptr: got %b/%h want 1/0000000a", wr_en, din);
    end
    p_req = 2'b00;
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_alternate_until_full();
    test_read_wait_empty();
    test_rr_wrap();
    test_timeout();
    test_err_paths();
    test_full_blocks();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fifo_arbiter.md
FIFO_ARBITER -- requirements
Module: fifo_arbiter

Interface
REQ-001 Parameter: DATA_W, 32, data width of every data port.
REQ-002 Parameter: TMO, 4, maximum cycles to wait for a FIFO response.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 p_req  input  2  producer write requests (bit i = producer i), held until p_ack[i] or p_err[i].
REQ-006 p_din0, p_din1  input  DATA_W each  producer write data, stable while the request is held.
REQ-007 p_ack, p_err  output  2 each  one-cycle write completion pulses, success or failure.
REQ-008 c_req  input  2  consumer read requests, held until c_ack[i] or c_err[i].
REQ-009 c_ack, c_err  output  2 each  one-cycle read completion pulses, success or failure.
REQ-010 c_dout  output  DATA_W  read data, valid in the c_ack cycle only.
REQ-011 wr_en, rd_en  output  1 each  FIFO commands; never both high in the same cycle.
REQ-012 din  output  DATA_W  FIFO write data.
REQ-013 dout  input  DATA_W  FIFO read data.
REQ-014 data_count  input  4  FIFO occupancy, 0..8.
REQ-015 wr_ack, wr_err, rd_ack, rd_err  input  1 each  FIFO response flags.

Function
REQ-016 FSM states: IDLE, ISSUE, WAIT.
REQ-017 IDLE: eligible set is p_req[i] when data_count<8, and c_req[i] when data_count!=0; if the set is non-empty, latch the winner and go to ISSUE, else stay in IDLE.
REQ-018 Arbitration: round-robin over the order P0,P1,C0,C1; a 2-bit pointer moves to the winner+1 mod 4 on each grant; search starts at the pointer.
REQ-019 ISSUE: assert wr_en (write winner, din = winner's p_din) or rd_en (read winner) for exactly one cycle; go to WAIT; clear the timeout counter.
REQ-020 WAIT, write winner: wr_ack -> p_ack[w] pulse; wr_err -> p_err[w] pulse; either -> IDLE.
REQ-021 WAIT, read winner: rd_ack -> c_ack[w] pulse with c_dout = dout sampled that cycle; rd_err -> c_err[w] pulse; either -> IDLE.
REQ-022 Timeout: counter increments each WAIT cycle with no response; at TMO, pulse the winner's err output and go to IDLE.
REQ-023 Only one operation is in flight at a time; minimum grant-to-ack latency is 3 cycles (IDLE grant, ISSUE, WAIT response).
REQ-024 A requester with no eligible slot (full for writers, empty for readers) is not granted and waits; no err pulse is produced.
REQ-025 Dropping a request before completion is illegal; the completion pulse is still produced for the latched winner.
REQ-026 When ack and err arrive together, err wins.
REQ-027 All outputs are registered except wr_en, rd_en and din, which decode from ISSUE state.

Reset
REQ-028 reset_n low, asynchronously: state=IDLE, pointer=P0, counter=0, all ack/err=0, wr_en=rd_en=0, c_dout=0.
REQ-029 Reset during ISSUE or WAIT abandons the operation with no completion pulse.

Structure
REQ-030 Shared package holds the state encodings, the requester index constants (P0=0, P1=1, C0=2, C1=3) and the default values of DATA_W and TMO.
REQ-031 One sub-module, rr_pick4: request vector plus pointer in, one-hot grant out, combinational.

Verification
REQ-032 Empty FIFO, p_req=01 with p_din0=0xA5 -> wr_en with din=0xA5 in cycle 2; wr_ack -> p_ack=01 in cycle 3.
REQ-033 Both producers request continuously from data_count=0 -> grants alternate P0,P1,P0,P1; after 8 writes no further wr_en, and no p_err.
REQ-034 data_count=0, c_req=10 -> no rd_en; once data_count=1 -> rd_en, then c_ack=10 with c_dout equal to dout.
REQ-035 All four requesters active, data_count=4 -> grant order P0,P1,C0,C1 and the pointer wraps to P0.
REQ-036 FIFO never responds after rd_en -> c_err pulses exactly TMO=4 cycles into WAIT, FSM returns to IDLE.
REQ-037 reset_n pulled low while in WAIT -> all outputs 0 immediately, no completion pulse, next grant starts at P0.
